// File: rtl/fpga_cmd_pkg.sv
// fpga_cmd_pkg -- shared definitions for the FPGA command SPI master.
//   FRAME_W               : bits per serial frame
//   FPGA_CMD_SET_CONFREG  : opcode that updates the configuration shadow
//   FPGA_CMD_SET_DIVISOR  : opcode that updates the divisor shadow
//   state_t               : frame sequencer states
package fpga_cmd_pkg;
   localparam int FRAME_W = 16;
   localparam logic [3:0] FPGA_CMD_SET_CONFREG = 4'b0001;
   localparam logic [3:0] FPGA_CMD_SET_DIVISOR = 4'b0010;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;
endpackage

// File: rtl/spck_divider.sv
// spck_divider -- half-period counter for the serial clock.
//   pck0  : clock
//   nrst  : synchronous active-low reset
//   en    : count while high, counter parked at zero otherwise
//   level : current spck level, selects which strobe a tick becomes
//   tick  : last cycle of a half period
//   rise  : tick while spck is low (spck goes high at this edge)
//   fall  : tick while spck is high (spck goes low at this edge)
module spck_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic pck0,
   input  logic nrst,
   input  logic en,
   input  logic level,
   output logic tick,
   output logic rise,
   output logic fall
);
   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt;

   assign tick = en && (cnt == LAST);
   assign rise = tick && !level;
   assign fall = tick && level;

   always_ff @(posedge pck0) begin
      if (!nrst)             cnt <= '0;
      else if (!en || tick)  cnt <= '0;
      else                   cnt <= cnt + 8'd1;
   end
endmodule

// File: rtl/fpga_cmd_spi_master.sv
// fpga_cmd_spi_master -- sends 16-bit command frames {op, 4'b0, data} MSB
// first over a spck/mosi/ncs link and mirrors the last conf/divisor values.
//   pck0, nrst          : clock, synchronous active-low reset
//   cmd_valid/ready     : command handshake, ready only in IDLE
//   cmd_op, cmd_data    : opcode and payload
//   spck, mosi, ncs     : serial link (spck idle low, ncs active low)
//   miso                : readback serial data
//   done                : one-cycle pulse when the frame ends
//   rx_data             : readback word of the last frame
//   shadow_conf/div     : mirrors of the last conf / divisor payloads
// Optional macro FPGA_CMD_READBACK_EN: enables miso capture into rx_data;
// without it rx_data is tied to zero.
module fpga_cmd_spi_master
   import fpga_cmd_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 4
) (
   input  logic               pck0,
   input  logic               nrst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3:0]         cmd_op,
   input  logic [7:0]         cmd_data,
   output logic               spck,
   output logic               mosi,
   output logic               ncs,
   input  logic               miso,
   output logic               done,
   output logic [FRAME_W-1:0] rx_data,
   output logic [7:0]         shadow_conf,
   output logic [7:0]         shadow_div
);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

   state_t             state, state_nx;
   logic [FRAME_W-1:0] sh;
   logic [3:0]         op_q;
   logic [7:0]         data_q;
   logic [4:0]         bit_cnt;
   logic [7:0]         gap_cnt;
   logic               spck_q;
   logic               done_q;
   logic               tick, rise, fall;
   logic               in_frame;

   assign in_frame  = (state == ST_SHIFT) || (state == ST_HOLD);
   assign cmd_ready = nrst && (state == ST_IDLE);
   assign ncs       = !in_frame;
   assign spck      = spck_q;
   // Shifter empties as bits go out, so mosi falls to 0 after the last bit.
   assign mosi      = sh[FRAME_W-1];
   assign done      = done_q;

   // Divider keeps running through HOLD so its tick also times the hold.
   spck_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .pck0  (pck0),
      .nrst  (nrst),
      .en    (in_frame),
      .level (spck_q),
      .tick  (tick),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge pck0) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (cmd_valid)                     state_nx = ST_SHIFT;
         ST_SHIFT: if (fall && (bit_cnt == 5'd15))    state_nx = ST_HOLD;
         ST_HOLD:  if (tick)                          state_nx = ST_GAP;
         ST_GAP:   if (gap_cnt == GAP_LAST)           state_nx = ST_IDLE;
         default:                                     state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge pck0) begin
      if (!nrst) begin
         sh          <= '0;
         op_q        <= '0;
         data_q      <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         spck_q      <= 1'b0;
         done_q      <= 1'b0;
         shadow_conf <= '0;
         shadow_div  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: if (cmd_valid) begin
               sh      <= {cmd_op, 4'b0000, cmd_data};
               op_q    <= cmd_op;
               data_q  <= cmd_data;
               bit_cnt <= '0;
            end
            ST_SHIFT: begin
               if (rise) spck_q <= 1'b1;
               if (fall) begin
                  spck_q  <= 1'b0;
                  sh      <= {sh[FRAME_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            ST_HOLD: if (tick) begin
               done_q  <= 1'b1;
               gap_cnt <= '0;
               if (op_q == FPGA_CMD_SET_CONFREG) shadow_conf <= data_q;
               if (op_q == FPGA_CMD_SET_DIVISOR) shadow_div  <= data_q;
            end
            ST_GAP: gap_cnt <= gap_cnt + 8'd1;
            default: ;
         endcase
      end
   end

`ifdef FPGA_CMD_READBACK_EN
   logic [FRAME_W-1:0] rx_sh;
   logic [FRAME_W-1:0] rx_q;

   always_ff @(posedge pck0) begin
      if (!nrst) begin
         rx_sh <= '0;
         rx_q  <= '0;
      end else begin
         if ((state == ST_SHIFT) && rise) rx_sh <= {rx_sh[FRAME_W-2:0], miso};
         if ((state == ST_HOLD) && tick)  rx_q  <= rx_sh;
      end
   end
   assign rx_data = rx_q;
`else
   logic unused_miso;
   assign unused_miso = miso;
   assign rx_data     = '0;
`endif
endmodule

// File: tb/tb_fpga_cmd_spi_master.sv
// tb_fpga_cmd_spi_master -- self-checking bench for fpga_cmd_spi_master.
// Frame waveforms are predicted cycle by cycle from closed-form timing
// (cycle c counted from the accept edge) and compared against the DUT.
`timescale 1ns/1ps
module tb_fpga_cmd_spi_master;
   localparam int D  = 4;
   localparam int G  = 4;
   localparam int D1 = 1;
   localparam int G1 = 2;

   logic        pck0 = 1'b0;
   logic        nrst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [3:0]  cmd_op = '0;
   logic [7:0]  cmd_data = '0;
   logic        miso = 1'b0;
   logic        cmd_ready, spck, mosi, ncs, done;
   logic [15:0] rx_data;
   logic [7:0]  shadow_conf, shadow_div;

   logic        valid_b = 1'b0;
   logic [3:0]  op_b = '0;
   logic [7:0]  data_b = '0;
   logic        ready_b, spck_b, mosi_b, ncs_b, done_b;
   logic [15:0] rx_b;
   logic [7:0]  conf_b, div_b;

   always #5 pck0 = ~pck0;

   fpga_cmd_spi_master #(.CLK_DIV(D), .GAP_CYC(G)) dut (
      .pck0(pck0), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .spck(spck), .mosi(mosi),
      .ncs(ncs), .miso(miso), .done(done), .rx_data(rx_data),
      .shadow_conf(shadow_conf), .shadow_div(shadow_div)
   );

   fpga_cmd_spi_master #(.CLK_DIV(D1), .GAP_CYC(G1)) dut_b (
      .pck0(pck0), .nrst(nrst), .cmd_valid(valid_b), .cmd_ready(ready_b),
      .cmd_op(op_b), .cmd_data(data_b), .spck(spck_b), .mosi(mosi_b),
      .ncs(ncs_b), .miso(1'b0), .done(done_b), .rx_data(rx_b),
      .shadow_conf(conf_b), .shadow_div(div_b)
   );

   int passed = 0;
   int total  = 0;
   logic [7:0] m_conf = '0;
   logic [7:0] m_div  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // spck is high during the second half of each 2*d window of the shift phase
   function automatic logic exp_spck(input int c, input int d);
      if (c >= 1 && c <= 32*d) return (((c-1)/d) % 2) == 1;
      return 1'b0;
   endfunction

   // bit n is on mosi after n falls; nothing left after the 16th
   function automatic logic exp_mosi(input int c, input int d, input logic [15:0] w);
      if (c >= 1 && c <= 32*d) return w[15 - (c-1)/(2*d)];
      return 1'b0;
   endfunction

   function automatic logic [15:0] exp_rx(input logic [15:0] rb);
`ifdef FPGA_CMD_READBACK_EN
      return rb;
`else
      return rb & 16'h0000;
`endif
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 400) begin @(negedge pck0); n++; end
      check("ready_wait", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic do_frame(input logic [3:0] op, input logic [7:0] d,
                           input bit pulses, input logic [15:0] rb);
      logic [15:0] w;
      int bad, rises, dones;
      logic ps;
      w = {op, 4'b0000, d};
      wait_ready();
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(posedge pck0); #1 cmd_valid = 1'b0;
      bad = 0; rises = 0; dones = 0; ps = 1'b0;
      for (int c = 1; c <= 33*D + G + 1; c++) begin
         @(negedge pck0);
         if (ncs !== (c > 33*D))                bad++;
         if (spck !== exp_spck(c, D))           bad++;
         if (mosi !== exp_mosi(c, D, w))        bad++;
         if (done !== (c == 33*D + 1))          bad++;
         if (cmd_ready !== (c >= 33*D + G + 1)) bad++;
         if (spck !== ps && ncs)                bad++;
         if (spck && !ps) rises++;
         if (done) dones++;
         ps = spck;
         // readback bit k must be stable at the k-th rise edge
         if (c <= 32*D) miso = rb[15 - (c-1)/(2*D)];
         if (pulses && (c == 20 || c == 60 || c == 100)) begin
            cmd_valid = 1'b1; cmd_op = 4'($urandom); cmd_data = 8'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
      end
      if (op == 4'h1) m_conf = d;
      if (op == 4'h2) m_div  = d;
      check("frame_wave_errors", bad, 0);
      check("frame_rises", rises, 16);
      check("frame_dones", dones, 1);
      check("shadow_conf", {24'd0, shadow_conf}, {24'd0, m_conf});
      check("shadow_div", {24'd0, shadow_div}, {24'd0, m_div});
      check("rx_data", {16'd0, rx_data}, {16'd0, exp_rx(rb)});
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  data;
      logic [15:0] rb;
      logic [7:0]  conf;
      logic [7:0]  div;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int   rise_t, fall2_t, dn, rises, n, low, bad;
      logic pn, ps;
      tbl[0] = '{4'h1, 8'hA5, 16'hC3E1, 8'hA5, 8'h00};
      tbl[1] = '{4'h2, 8'h5F, 16'h1234, 8'hA5, 8'h5F};
      tbl[2] = '{4'h7, 8'h3C, 16'hFFFF, 8'hA5, 8'h5F};
      tbl[3] = '{4'h0, 8'hFF, 16'h0001, 8'hA5, 8'h5F};
      tbl[4] = '{4'h1, 8'h00, 16'h8000, 8'h00, 8'h5F};

      // reset state
      repeat (3) @(posedge pck0);
      @(negedge pck0);
      check("rst_ncs", {31'd0, ncs}, 1);
      check("rst_spck", {31'd0, spck}, 0);
      check("rst_mosi", {31'd0, mosi}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_ready", {31'd0, cmd_ready}, 0);
      check("rst_rx", {16'd0, rx_data}, 0);
      check("rst_conf", {24'd0, shadow_conf}, 0);
      check("rst_div", {24'd0, shadow_div}, 0);
      nrst = 1'b1;
      @(negedge pck0);
      check("ready_after_release", {31'd0, cmd_ready}, 1);

      foreach (tbl[i]) begin
         do_frame(tbl[i].op, tbl[i].data, 1'b0, tbl[i].rb);
         check("tbl_conf", {24'd0, shadow_conf}, {24'd0, tbl[i].conf});
         check("tbl_div", {24'd0, shadow_div}, {24'd0, tbl[i].div});
      end

      for (int i = 0; i < 6; i++)
         do_frame(4'($urandom_range(0, 3)), 8'($urandom), 1'b1, 16'($urandom));

      // back-to-back with cmd_valid held high
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 4'h1; cmd_data = 8'h11;
      @(posedge pck0); #1 cmd_op = 4'h2; cmd_data = 8'h22;
      rise_t = -1; fall2_t = -1; dn = 0; pn = ncs;
      for (int t = 1; t < 600 && dn < 2; t++) begin
         @(negedge pck0);
         if (ncs && !pn && rise_t < 0) rise_t = t;
         if (!ncs && pn && rise_t >= 0 && fall2_t < 0) begin fall2_t = t; cmd_valid = 1'b0; end
         if (done) dn++;
         pn = ncs;
      end
      cmd_valid = 1'b0;
      m_conf = 8'h11; m_div = 8'h22;
      check("b2b_gap", fall2_t - rise_t, G + 1);
      check("b2b_dones", dn, 2);
      check("b2b_conf", {24'd0, shadow_conf}, {24'd0, m_conf});
      check("b2b_div", {24'd0, shadow_div}, {24'd0, m_div});

      // reset at the 8th rise
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 4'h1; cmd_data = 8'h77;
      @(posedge pck0); #1 cmd_valid = 1'b0;
      rises = 0; ps = 1'b0; n = 0;
      while (rises < 8 && n < 500) begin
         @(negedge pck0);
         if (spck && !ps) rises++;
         ps = spck; n++;
      end
      check("rst_reach_8th_rise", rises, 8);
      nrst = 1'b0;
      @(negedge pck0);
      m_conf = '0; m_div = '0;
      check("midrst_ncs", {31'd0, ncs}, 1);
      check("midrst_spck", {31'd0, spck}, 0);
      check("midrst_done", {31'd0, done}, 0);
      check("midrst_ready", {31'd0, cmd_ready}, 0);
      check("midrst_conf", {24'd0, shadow_conf}, 0);
      check("midrst_div", {24'd0, shadow_div}, 0);
      @(negedge pck0);
      check("midrst_no_done", {31'd0, done}, 0);
      nrst = 1'b1;
      @(negedge pck0);
      check("midrst_ready_after", {31'd0, cmd_ready}, 1);
      do_frame(4'h2, 8'h9C, 1'b0, 16'h5A5A);

      // CLK_DIV=1 instance
      n = 0;
      while (ready_b !== 1'b1 && n < 200) begin @(negedge pck0); n++; end
      check("b_ready", {31'd0, ready_b}, 1);
      valid_b = 1'b1; op_b = 4'h1; data_b = 8'h3D;
      @(posedge pck0); #1 valid_b = 1'b0;
      low = 0; rises = 0; dn = 0; bad = 0; ps = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge pck0);
         if (!ncs_b) low++;
         if (spck_b && !ps) rises++;
         if (done_b) dn++;
         if (spck_b !== exp_spck(c, D1)) bad++;
         if (mosi_b !== exp_mosi(c, D1, 16'h103D)) bad++;
         ps = spck_b;
      end
      check("b_ncs_low", low, 33);
      check("b_rises", rises, 16);
      check("b_dones", dn, 1);
      check("b_wave_errors", bad, 0);
      check("b_conf", {24'd0, conf_b}, 32'h3D);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
